// File: rtl/proc_pkg.sv
// Shared types and constants for the downsampling processor front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: fetch FSM state enum, instruction/immediate widths, default
// address width, and a wrapping PC increment helper.
package proc_pkg;

    localparam int ADDR_W_DEF = 8;  // default instruction address / PC width
    localparam int INSTR_W    = 8;  // instruction word width
    localparam int IMM_W      = 4;  // immediate field width inside an instruction

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } fetch_state_e;

    // Wrapping increment: all-ones rolls over to zero silently.
    function automatic logic [ADDR_W_DEF-1:0] pc_inc8(input logic [ADDR_W_DEF-1:0] pc);
        return pc + ADDR_W_DEF'(1);
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: controller requests, instruction memory read port, IR output.
// Latency: n/a (wires only).
// Backpressure: memory stalls the fetch by withholding im_ack.
//
// Modports:
//   slave  - the fetch stage (instr_fetch)
//   master - controller + instruction memory side (drives requests and read data)
interface instr_fetch_if
    import proc_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
);
    // controller -> fetch
    logic                fetch_req;
    logic                pc_load;
    logic [ADDR_W-1:0]   pc_load_addr;
    // fetch <-> instruction memory
    logic [ADDR_W-1:0]   im_addr;
    logic                im_rd;
    logic [INSTR_W-1:0]  im_data;
    logic                im_ack;
    // fetch -> instruction register / controller
    logic [INSTR_W-1:0]  ir_in;
    logic                ir_valid;
    logic [ADDR_W-1:0]   pc;
    logic                busy;
    logic                fetch_err;

    modport slave (
        input  fetch_req, pc_load, pc_load_addr, im_data, im_ack,
        output im_addr, im_rd, ir_in, ir_valid, pc, busy, fetch_err
    );

    modport master (
        output fetch_req, pc_load, pc_load_addr, im_data, im_ack,
        input  im_addr, im_rd, ir_in, ir_valid, pc, busy, fetch_err
    );

endinterface

// File: rtl/pc_counter.sv
// Program counter register with priority load and wrapping increment.
// Latency: load/increment visible one cycle after the strobe.
// Backpressure: none; caller decides when to load or increment.
//
// Ports:
//   clk, RST       clock, synchronous active-low reset (to RESET_PC)
//   load_i         load load_addr_i (wins over inc_i)
//   load_addr_i    jump target
//   inc_i          advance by one, all-ones wraps to zero
//   pc_o           current program counter
module pc_counter #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_addr_i;
        end else if (inc_i) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!RST) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, read handshake to instruction memory, one-cycle IR load pulse.
// Latency: request edge -> im_rd next cycle; im_ack edge -> ir_valid/ir_in/pc+1 same edge (>=2 cycles/fetch).
// Backpressure: memory stalls by holding im_ack low; requests and jumps are accepted only while idle.
//
// Ports:
//   clk, RST  clock, synchronous active-low reset
//   bus       instr_fetch_if.slave: fetch_req/pc_load/pc_load_addr from the controller,
//             im_addr/im_rd/im_data/im_ack to memory, ir_in/ir_valid/pc/busy/fetch_err out.
//
// Build option IFETCH_ACK_TIMEOUT_EN: abandon a read after TIMEOUT cycles without
// im_ack and set the sticky fetch_err flag. Without it REQ waits forever and
// fetch_err is tied low.
module instr_fetch
    import proc_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                TIMEOUT  = 16
) (
    input  logic         clk,
    input  logic         RST,
    instr_fetch_if.slave bus
);

    fetch_state_e        state_q;
    logic [ADDR_W-1:0]   im_addr_q;
    logic                im_rd_q;
    logic [INSTR_W-1:0]  ir_in_q;
    logic                ir_valid_q;

    logic [ADDR_W-1:0]   pc_w;
    logic                idle_w;
    logic                load_w;
    logic                done_w;

    assign idle_w = (state_q == IDLE);
    // Jumps and requests are only honoured in IDLE; acks only in REQ.
    assign load_w = idle_w && bus.pc_load;
    assign done_w = (state_q == REQ) && bus.im_ack;

    pc_counter #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk         (clk),
        .RST         (RST),
        .load_i      (load_w),
        .load_addr_i (bus.pc_load_addr),
        .inc_i       (done_w),
        .pc_o        (pc_w)
    );

`ifdef IFETCH_ACK_TIMEOUT_EN
    // Counter value seen in the last permitted REQ cycle; reaching it without
    // an ack abandons the read on that edge, so REQ lasts exactly TIMEOUT cycles.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    logic [7:0] tmo_cnt_q;
    logic       fetch_err_q;
`endif

    always_ff @(posedge clk) begin
        if (!RST) begin
            state_q    <= IDLE;
            im_addr_q  <= RESET_PC;
            im_rd_q    <= 1'b0;
            ir_in_q    <= '0;
            ir_valid_q <= 1'b0;
`ifdef IFETCH_ACK_TIMEOUT_EN
            tmo_cnt_q   <= '0;
            fetch_err_q <= 1'b0;
`endif
        end else begin
            ir_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.fetch_req) begin
                        // A simultaneous jump redirects this very fetch.
                        im_addr_q <= bus.pc_load ? bus.pc_load_addr : pc_w;
                        im_rd_q   <= 1'b1;
                        state_q   <= REQ;
`ifdef IFETCH_ACK_TIMEOUT_EN
                        tmo_cnt_q <= '0;
`endif
                    end
                end
                REQ: begin
                    if (bus.im_ack) begin
                        // Ack beats the timeout when both land on the same edge.
                        ir_in_q    <= bus.im_data;
                        ir_valid_q <= 1'b1;
                        im_rd_q    <= 1'b0;
                        state_q    <= IDLE;
                    end
`ifdef IFETCH_ACK_TIMEOUT_EN
                    else if (tmo_cnt_q == TMO_LAST) begin
                        im_rd_q     <= 1'b0;
                        state_q     <= IDLE;
                        fetch_err_q <= 1'b1;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 8'd1;
                    end
`endif
                end
                default: begin
                    state_q <= IDLE;
                    im_rd_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.im_addr  = im_addr_q;
    assign bus.im_rd    = im_rd_q;
    assign bus.ir_in    = ir_in_q;
    assign bus.ir_valid = ir_valid_q;
    assign bus.pc       = pc_w;
    assign bus.busy     = (state_q == REQ);

`ifdef IFETCH_ACK_TIMEOUT_EN
    assign bus.fetch_err = fetch_err_q;
`else
    // TIMEOUT only matters with the timeout counter built in.
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT);
    assign bus.fetch_err  = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: scoreboard of expected IR loads, popped by a monitor on ir_valid.
module tb_instr_fetch;
    import proc_pkg::*;

    localparam int          AW     = 8;
    localparam logic [7:0]  RST_PC = 8'h00;
    localparam int          TMO    = 4;

    logic clk = 1'b0;
    logic RST;

    always #5 clk = ~clk;

    instr_fetch_if #(.ADDR_W(AW)) bus ();

    instr_fetch #(
        .ADDR_W   (AW),
        .RESET_PC (RST_PC),
        .TIMEOUT  (TMO)
    ) dut (
        .clk (clk),
        .RST (RST),
        .bus (bus)
    );

    typedef struct packed {
        logic [7:0] ir;
        logic [7:0] pc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_fail = 0;
    logic exp_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every ir_valid pulse must match the oldest expected IR load.
    always @(negedge clk) begin
        if (bus.ir_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_valid: ir_valid=1 ir_in=%0h, expected no pulse (t=%0t)",
                         bus.ir_in, $time);
            end else begin
                mon_e = sb.pop_front();
                chk("ir_in", 32'(bus.ir_in), 32'(mon_e.ir));
                chk("pc_after_fetch", 32'(bus.pc), 32'(mon_e.pc));
            end
        end
    end

    // Controller protocol: no request or jump while the stage is busy.
    always @(posedge clk) begin
        if (RST && bus.busy) begin
            n_chk++;
            if (bus.fetch_req || bus.pc_load) begin
                n_fail++;
                $display("FAIL req_while_busy: fetch_req=%0b pc_load=%0b, expected both 0",
                         bus.fetch_req, bus.pc_load);
            end
        end
    end

    // Entered and left at a negedge. Holds ack off for 'waits' REQ cycles, then acks.
    task automatic do_fetch(input logic ld, input logic [7:0] ld_addr, input logic [7:0] data,
                            input int waits, input logic [7:0] exp_addr, input logic [7:0] exp_pc);
        bus.fetch_req    = 1'b1;
        bus.pc_load      = ld;
        bus.pc_load_addr = ld_addr;
        @(negedge clk);
        bus.fetch_req = 1'b0;
        bus.pc_load   = 1'b0;
        for (int c = 0; c <= waits; c++) begin
            chk("im_rd_held", 32'(bus.im_rd), 32'd1);
            chk("im_addr", 32'(bus.im_addr), 32'(exp_addr));
            chk("busy_req", 32'(bus.busy), 32'd1);
            chk("pc_hold", 32'(bus.pc), 32'(exp_addr));
            if (c == waits) begin
                bus.im_ack  = 1'b1;
                bus.im_data = data;
                sb.push_back(exp_t'{ir: data, pc: exp_pc});
            end else begin
                bus.im_data = 8'hEE;  // junk that must not be captured
            end
            @(negedge clk);
        end
        bus.im_ack  = 1'b0;
        bus.im_data = 8'h00;
        chk("im_rd_drop", 32'(bus.im_rd), 32'd0);
        chk("busy_drop", 32'(bus.busy), 32'd0);
        chk("fetch_err", 32'(bus.fetch_err), 32'(exp_err));
    endtask

    initial begin
        RST              = 1'b0;
        bus.fetch_req    = 1'b0;
        bus.pc_load      = 1'b0;
        bus.pc_load_addr = 8'h00;
        bus.im_data      = 8'h00;
        bus.im_ack       = 1'b1;   // stale ack through reset
        repeat (3) @(negedge clk);

        chk("rst_pc", 32'(bus.pc), 32'(RST_PC));
        chk("rst_im_addr", 32'(bus.im_addr), 32'(RST_PC));
        chk("rst_im_rd", 32'(bus.im_rd), 32'd0);
        chk("rst_ir_in", 32'(bus.ir_in), 32'd0);
        chk("rst_ir_valid", 32'(bus.ir_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_fetch_err", 32'(bus.fetch_err), 32'd0);

        RST = 1'b1;
        @(negedge clk);
        bus.im_ack = 1'b0;
        chk("stale_ack_busy", 32'(bus.busy), 32'd0);
        chk("stale_ack_pc", 32'(bus.pc), 32'(RST_PC));
        chk("stale_ack_im_rd", 32'(bus.im_rd), 32'd0);

        // Single fetch with immediate ack.
        do_fetch(1'b0, 8'h00, 8'hA5, 0, 8'h00, 8'h01);
        // Three wait states: strobe/address held for four cycles.
        do_fetch(1'b0, 8'h00, 8'h3C, 3, 8'h01, 8'h02);

        // Plain jump to 5.
        bus.pc_load      = 1'b1;
        bus.pc_load_addr = 8'h05;
        @(negedge clk);
        bus.pc_load = 1'b0;
        chk("jump_pc", 32'(bus.pc), 32'h05);
        chk("jump_no_rd", 32'(bus.im_rd), 32'd0);
        chk("jump_not_busy", 32'(bus.busy), 32'd0);

        // Jump and request together: fetch uses the new target.
        do_fetch(1'b1, 8'h40, 8'h77, 0, 8'h40, 8'h41);
        // Back-to-back fetch, one wait state.
        do_fetch(1'b0, 8'h00, 8'h12, 1, 8'h41, 8'h42);
        // Wrap from FF to 00.
        do_fetch(1'b1, 8'hFF, 8'h11, 0, 8'hFF, 8'h00);

        repeat (2) @(negedge clk);
        chk("ir_hold", 32'(bus.ir_in), 32'h11);

`ifdef IFETCH_ACK_TIMEOUT_EN
        // Ack in the last permitted cycle still completes.
        do_fetch(1'b0, 8'h00, 8'h5A, TMO - 1, 8'h00, 8'h01);

        // No ack at all: abandoned after TMO REQ cycles.
        bus.fetch_req = 1'b1;
        @(negedge clk);
        bus.fetch_req = 1'b0;
        for (int c = 0; c < TMO; c++) begin
            chk("tmo_busy", 32'(bus.busy), 32'd1);
            chk("tmo_im_rd", 32'(bus.im_rd), 32'd1);
            @(negedge clk);
        end
        chk("tmo_abandon_busy", 32'(bus.busy), 32'd0);
        chk("tmo_abandon_im_rd", 32'(bus.im_rd), 32'd0);
        chk("tmo_err_set", 32'(bus.fetch_err), 32'd1);
        chk("tmo_pc_unchanged", 32'(bus.pc), 32'h01);
        chk("tmo_ir_unchanged", 32'(bus.ir_in), 32'h5A);
        exp_err = 1'b1;

        // Later fetch succeeds; the error flag stays set.
        do_fetch(1'b0, 8'h00, 8'hC3, 0, 8'h01, 8'h02);
`else
        // Long stall: no timeout exists, fetch completes and no error appears.
        do_fetch(1'b0, 8'h00, 8'h5A, 20, 8'h00, 8'h01);
`endif

        // Reset in the middle of a fetch to 0x20.
        bus.fetch_req    = 1'b1;
        bus.pc_load      = 1'b1;
        bus.pc_load_addr = 8'h20;
        @(negedge clk);
        bus.fetch_req = 1'b0;
        bus.pc_load   = 1'b0;
        chk("midrst_busy_before", 32'(bus.busy), 32'd1);
        chk("midrst_addr_before", 32'(bus.im_addr), 32'h20);
        RST = 1'b0;
        @(negedge clk);
        RST = 1'b1;
        exp_err = 1'b0;
        chk("midrst_im_rd", 32'(bus.im_rd), 32'd0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_pc", 32'(bus.pc), 32'(RST_PC));
        chk("midrst_fetch_err", 32'(bus.fetch_err), 32'd0);
        bus.im_ack  = 1'b1;
        bus.im_data = 8'h99;
        @(negedge clk);
        bus.im_ack  = 1'b0;
        bus.im_data = 8'h00;
        chk("late_ack_im_rd", 32'(bus.im_rd), 32'd0);
        chk("late_ack_pc", 32'(bus.pc), 32'(RST_PC));
        chk("late_ack_ir_in", 32'(bus.ir_in), 32'h00);

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
